// File: rtl/ttl_74164_shift_ctrl_if.sv
// Command handshake between the IO decode logic and the 74164 shift sequencer.
interface ttl_74164_shift_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             req_valid;
   logic             req_ready;
   logic             req_clear;
   logic [WIDTH-1:0] req_data;

   modport master (
      output req_valid,
      output req_clear,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_clear,
      input  req_data,
      output req_ready
   );
endinterface

// File: rtl/ttl_74164_shift_ctrl.sv
// Serialises words (or clears) into a 74164 chain with one clean Cen pulse per bit.
// Define TTL164_SHIFT_CTRL_LSB_FIRST_EN to shift req_data[0] first (default MSB first).
module ttl_74164_shift_ctrl #(
   parameter int WIDTH       = 8,
   parameter int HALF_PERIOD = 2,
   parameter int CLR_CYCLES  = 2
) (
   input  logic                  clk,
   input  logic                  Reset_n,
   ttl_74164_shift_ctrl_if.slave req,
   output logic                  ser_A,
   output logic                  ser_B,
   output logic                  sh_cen,
   output logic                  sh_mrn,
   output logic                  busy,
   output logic                  done
);
   localparam int TMAX = (HALF_PERIOD > CLR_CYCLES) ? HALF_PERIOD : CLR_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int CW   = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_LOW   = 2'd2;
   localparam logic [1:0] S_HIGH  = 2'd3;

   localparam logic [TW-1:0] T_HALF = TW'(HALF_PERIOD - 1);
   localparam logic [TW-1:0] T_CLR  = TW'(CLR_CYCLES - 1);
   localparam logic [CW-1:0] C_LOAD = CW'(WIDTH);

   logic [1:0]       state_q, state_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] buf_q, buf_d;
   logic             rdy_q, rdy_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic             cen_q, cen_d;
   logic             mrn_q, mrn_d;
   logic [WIDTH-1:0] buf_adv;

   function automatic logic lead(input logic [WIDTH-1:0] v);
`ifdef TTL164_SHIFT_CTRL_LSB_FIRST_EN
      return v[0];
`else
      return v[WIDTH-1];
`endif
   endfunction

`ifdef TTL164_SHIFT_CTRL_LSB_FIRST_EN
   assign buf_adv = buf_q >> 1;
`else
   assign buf_adv = buf_q << 1;
`endif

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      rdy_d   = rdy_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      sa_d    = sa_q;
      sb_d    = sb_q;
      cen_d   = cen_q;
      mrn_d   = mrn_q;
      unique case (state_q)
         S_IDLE: begin
            if (req.req_valid && rdy_q) begin
               rdy_d  = 1'b0;
               busy_d = 1'b1;
               if (req.req_clear) begin
                  state_d = S_CLEAR;
                  tmr_d   = T_CLR;
                  mrn_d   = 1'b0;
               end else begin
                  state_d = S_LOW;
                  tmr_d   = T_HALF;
                  cnt_d   = C_LOAD;
                  buf_d   = req.req_data;
                  sa_d    = lead(req.req_data);
                  sb_d    = 1'b1;
                  cen_d   = 1'b0;
               end
            end
         end
         S_CLEAR: begin
            if (tmr_q == '0) begin
               state_d = S_IDLE;
               mrn_d   = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               rdy_d   = 1'b1;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         S_LOW: begin
            if (tmr_q == '0) begin
               state_d = S_HIGH;
               tmr_d   = T_HALF;
               cen_d   = 1'b1;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         S_HIGH: begin
            if (tmr_q == '0) begin
               cnt_d = cnt_q - CW'(1);
               cen_d = 1'b0;
               // Data only moves here, while Cen falls, so it never races the rise.
               if (cnt_q > CW'(1)) begin
                  state_d = S_LOW;
                  tmr_d   = T_HALF;
                  buf_d   = buf_adv;
                  sa_d    = lead(buf_adv);
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  rdy_d   = 1'b1;
                  sa_d    = 1'b0;
                  sb_d    = 1'b0;
               end
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
         rdy_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         cen_q   <= 1'b0;
         mrn_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         cen_q   <= cen_d;
         mrn_q   <= mrn_d;
      end
   end

   assign req.req_ready = rdy_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign ser_A         = sa_q;
   assign ser_B         = sb_q;
   assign sh_cen        = cen_q;
   assign sh_mrn        = mrn_q;
endmodule
